imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//   Byte-serial program loader: the write side of the instruction memory, which the fetch path only reads.
//   Accepts a framed byte stream (length, payload, XOR checksum) over a valid/ready handshake.
//   Writes payload bytes in arrival order: first byte to BASE_ADDR (instruction bits [31:24]).
//   Holds the processor in reset (CPU_RESET) until a frame completes with a good checksum.
// PARAMETERS
//   ADDR_WIDTH  10  instruction-memory byte address width (1024 bytes)
//   BASE_ADDR   0   byte address receiving the first payload byte; must be a multiple of 4
// PORTS
//   CLK        in   1           clock; all state changes on posedge
//   RESET      in   1           synchronous, active-high reset
//   START      in   1           one-cycle pulse: begin a new frame
//   RxData     in   8           incoming stream byte
//   RxValid    in   1           RxData valid
//   RxReady    out  1           loader can accept a byte this cycle
//   MemWE      out  1           instruction-memory byte write strobe
//   MemAddr    out  ADDR_WIDTH  write byte address
//   MemData    out  8           write byte
//   CPU_RESET  out  1           hold processor (PC etc.) in reset
//   Done       out  1           frame loaded, checksum OK (sticky)
//   Error      out  1           frame rejected (sticky)
//   ByteCount  out  16          payload bytes written in current frame
// BEHAVIOUR
//   Clock and reset
//   - One clock, CLK; RESET synchronous active-high.
//   - On RESET: state IDLE; RxReady=0, MemWE=0, MemAddr=0, MemData=0, Done=0, Error=0, ByteCount=0, CPU_RESET=1.
//   - RESET mid-frame aborts the frame. Bytes already written stay in memory; nothing is rolled back.
//   Handshake
//   - A byte is accepted on a posedge where RxValid && RxReady.
//   - RxReady is a registered output: high only in LEN_HI, LEN_LO, DATA and CHECK; 0 in all other states.
//   - RxData is ignored when not accepted.
//   States
//   - IDLE: START -> LEN_HI; CPU_RESET=1.
//   - LEN_HI: accept byte -> Len[15:8]; go to LEN_LO.
//   - LEN_LO: accept byte -> Len[7:0]; evaluate the assembled length:
//     - Len[1:0]!=0 or Len > 2^ADDR_WIDTH-BASE_ADDR -> ERROR;
//     - Len==0 -> CHECK;
//     - otherwise -> DATA, with idx=0 and chk=0.
//   - DATA, on each accepted byte:
//     - next cycle: MemWE=1, MemAddr=BASE_ADDR+idx, MemData=byte;
//     - chk ^= byte; idx++; ByteCount=idx.
//     - After the byte with idx==Len-1: -> CHECK.
//   - CHECK: accept byte; byte==chk -> DONE, else -> ERROR.
//   - DONE: Done=1, CPU_RESET=0 from the cycle after entry; START -> LEN_HI.
//   - ERROR: Error=1, CPU_RESET=1; START -> LEN_HI.
//   Outputs
//   - MemWE is one cycle wide and exactly one cycle after acceptance, so latency is 1.
//   - MemWE is 0 in all non-DATA cycles.
//   - START clears Done, Error and ByteCount and reasserts CPU_RESET in the same edge.
//   - START is ignored in LEN_HI, LEN_LO, DATA and CHECK; there is no restart mid-frame.
//   Arithmetic and widths
//   - idx, Len and ByteCount are 16-bit; MemAddr = BASE_ADDR + idx[ADDR_WIDTH-1:0].
//   - No address wrap is possible: the length check rejects overflow.
//   - Back-to-back bytes (RxValid held high) are accepted every cycle, giving full throughput.
// TESTING
//   1. RESET=1 for 2 cycles -> CPU_RESET=1; MemWE=0, RxReady=0, Done=0, Error=0.
//   2. START; stream 00 04 00 01 10 20 31 (back-to-back):
//      -> MemWE pulses at addr 0..3 with 00,01,10,20; Done=1, CPU_RESET=0, ByteCount=4.
//   3. Same frame with checksum 30 -> Error=1, CPU_RESET=1, Done=0; the 4 bytes are still written.
//   4. START; length 00 06 -> Error=1 (not multiple of 4), no MemWE.
//      Also length 04 04 with ADDR_WIDTH=10 -> Error=1.
//   5. START; frame 00 00 00 -> Done=1 with zero MemWE pulses.
//   6. RxValid toggling 1/0 each cycle during DATA -> writes only on accepted bytes.
//      Then RESET after 2 payload bytes -> IDLE, CPU_RESET=1, ByteCount=0.

Source files
------------

// File: rtl/imem_loader.sv
// Byte-serial instruction-memory loader: framed stream (length, payload, XOR
// checksum) written to imem; keeps the CPU in reset until a good frame lands.
module imem_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  START,
  input  logic [7:0]            RxData,
  input  logic                  RxValid,
  output logic                  RxReady,
  output logic                  MemWE,
  output logic [ADDR_WIDTH-1:0] MemAddr,
  output logic [7:0]            MemData,
  output logic                  CPU_RESET,
  output logic                  Done,
  output logic                  Error,
  output logic [15:0]           ByteCount
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  // Largest payload that still fits above BASE_ADDR.
  localparam logic [16:0] LIMIT =
    17'((1 << ADDR_WIDTH) - BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] BASE =
    ADDR_WIDTH'(BASE_ADDR);

  state_t                state_q, state_d;
  logic [15:0]           len_q, len_d;
  logic [15:0]           idx_q, idx_d;
  logic [7:0]            chk_q, chk_d;
  logic                  rdy_q, rdy_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            data_q, data_d;
  logic                  cpu_rst_q, cpu_rst_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [15:0]           cnt_q, cnt_d;

  logic                  acc;
  logic [15:0]           len_full;

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    idx_d    = idx_q;
    chk_d    = chk_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    data_d   = data_q;
    cnt_d    = cnt_q;
    acc      = RxValid && rdy_q;
    len_full = {len_q[15:8], RxData};

    unique case (state_q)
      S_IDLE: begin
        if (START) state_d = S_LEN_HI;
      end
      S_LEN_HI: begin
        if (acc) begin
          len_d[15:8] = RxData;
          state_d     = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (acc) begin
          len_d = len_full;
          idx_d = '0;
          chk_d = '0;
          if (len_full[1:0] != 2'b00 ||
              {1'b0, len_full} > LIMIT)
            state_d = S_ERROR;
          else if (len_full == 16'd0)
            state_d = S_CHECK;
          else
            state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (acc) begin
          we_d   = 1'b1;
          addr_d = BASE + idx_q[ADDR_WIDTH-1:0];
          data_d = RxData;
          chk_d  = chk_q ^ RxData;
          idx_d  = idx_q + 16'd1;
          cnt_d  = idx_q + 16'd1;
          if (idx_q == len_q - 16'd1)
            state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (acc)
          state_d = (RxData == chk_q) ? S_DONE
                                      : S_ERROR;
      end
      S_DONE, S_ERROR: begin
        if (START) state_d = S_LEN_HI;
      end
      default: state_d = S_IDLE;
    endcase

    if (START && (state_q == S_IDLE ||
                  state_q == S_DONE ||
                  state_q == S_ERROR))
      cnt_d = '0;

    rdy_d = (state_d == S_LEN_HI) ||
            (state_d == S_LEN_LO) ||
            (state_d == S_DATA)   ||
            (state_d == S_CHECK);
    // Status flags follow the state one cycle later; START drops them at once.
    done_d    = (state_q == S_DONE) && !START;
    err_d     = (state_q == S_ERROR) && !START;
    cpu_rst_d = !done_d;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= S_IDLE;
      len_q     <= '0;
      idx_q     <= '0;
      chk_q     <= '0;
      rdy_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      cpu_rst_q <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      chk_q     <= chk_d;
      rdy_q     <= rdy_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      cpu_rst_q <= cpu_rst_d;
      done_q    <= done_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

  assign RxReady   = rdy_q;
  assign MemWE     = we_q;
  assign MemAddr   = addr_q;
  assign MemData   = data_q;
  assign CPU_RESET = cpu_rst_q;
  assign Done      = done_q;
  assign Error     = err_q;
  assign ByteCount = cnt_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed frames plus randomized frames checked
// against a frame-level model of expected writes and final status.
module tb_imem_loader;

  localparam int AW   = 10;
  localparam int BASE = 0;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_data;
  logic          cpu_rst;
  logic          done;
  logic          err;
  logic [15:0]   byte_cnt;

  always #5 clk = ~clk;

  imem_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
    .CLK(clk),
    .RESET(rst),
    .START(start),
    .RxData(rx_data),
    .RxValid(rx_valid),
    .RxReady(rx_ready),
    .MemWE(mem_we),
    .MemAddr(mem_addr),
    .MemData(mem_data),
    .CPU_RESET(cpu_rst),
    .Done(done),
    .Error(err),
    .ByteCount(byte_cnt)
  );

  int errors = 0;
  int checks = 0;

  logic [7:0]    pl[$];
  logic [AW+7:0] wq[$];

  always @(negedge clk)
    if (mem_we) wq.push_back({mem_addr, mem_data});

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // gaps: 0 back-to-back, 1 one idle cycle before each byte, 2 random idles
  task automatic send(input logic [7:0] b, input int gaps);
    int n;
    int idle;
    idle = (gaps == 1) ? 1 : (gaps == 2) ? $urandom_range(0, 2) : 0;
    repeat (idle) begin
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
      tick();
    end
    rx_valid = 1'b1;
    rx_data  = b;
    n = 0;
    while (rx_ready !== 1'b1 && n < 64) begin
      tick();
      n++;
    end
    if (rx_ready !== 1'b1) chk("rdy_timeout", 32'(rx_ready), 1);
    else tick();
  endtask

  function automatic logic [7:0] xsum(input int len);
    logic [7:0] x = 8'h00;
    for (int i = 0; i < len; i++) x ^= pl[i];
    return x;
  endfunction

  task automatic fill(input int len);
    pl.delete();
    for (int i = 0; i < len; i++) pl.push_back(8'($urandom));
  endtask

  task automatic frame(input logic [15:0] len,
                       input logic [7:0]  ck,
                       input int          gaps,
                       input string       tag);
    bit            ok_len;
    bit            good;
    int            n;
    logic [7:0]    x;
    logic [AW+7:0] e;
    ok_len = (len % 4 == 0) && (int'(len) <= (1 << AW) - BASE);
    wq.delete();
    pulse_start();
    chk({tag, "_st_done"}, 32'(done), 0);
    chk({tag, "_st_err"}, 32'(err), 0);
    chk({tag, "_st_cnt"}, 32'(byte_cnt), 0);
    chk({tag, "_st_cpurst"}, 32'(cpu_rst), 1);
    send(len[15:8], gaps);
    send(len[7:0], gaps);
    x = 8'h00;
    if (ok_len) begin
      for (int i = 0; i < int'(len); i++) begin
        send(pl[i], gaps);
        x ^= pl[i];
      end
      send(ck, gaps);
    end
    rx_valid = 1'b0;
    tick();
    tick();
    n    = ok_len ? int'(len) : 0;
    good = ok_len && (ck == x);
    chk({tag, "_nwr"}, 32'(wq.size()), 32'(n));
    for (int i = 0; i < n && i < wq.size(); i++) begin
      e = {AW'(BASE + i), pl[i]};
      chk($sformatf("%s_wr%0d", tag, i), 32'(wq[i]), 32'(e));
    end
    chk({tag, "_done"}, 32'(done), 32'(good));
    chk({tag, "_err"}, 32'(err), 32'(!good));
    chk({tag, "_cpurst"}, 32'(cpu_rst), 32'(!good));
    chk({tag, "_cnt"}, 32'(byte_cnt), 32'(n));
    chk({tag, "_we_idle"}, 32'(mem_we), 0);
    chk({tag, "_rdy_idle"}, 32'(rx_ready), 0);
  endtask

  initial begin
    logic [15:0]   len;
    logic [7:0]    ck;
    logic [AW+7:0] e;
    int            kind;

    rst      = 1'b1;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    tick();
    tick();
    chk("rst_cpurst", 32'(cpu_rst), 1);
    chk("rst_we", 32'(mem_we), 0);
    chk("rst_rdy", 32'(rx_ready), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_cnt", 32'(byte_cnt), 0);
    chk("rst_addr", 32'(mem_addr), 0);
    rst = 1'b0;
    tick();

    pl = '{8'h00, 8'h01, 8'h10, 8'h20};
    frame(16'd4, 8'h31, 0, "good4");
    frame(16'd4, 8'h30, 0, "badck4");

    pl.delete();
    frame(16'd6, 8'h00, 0, "len6");
    frame(16'h0404, 8'h00, 0, "len1028");
    frame(16'd0, 8'h00, 0, "len0");
    frame(16'd0, 8'h5a, 0, "len0bad");

    fill(1024);
    frame(16'd1024, xsum(1024), 0, "len1024");

    fill(12);
    frame(16'd12, xsum(12), 1, "toggle");

    // Abort mid-frame: earlier writes remain, loader returns to idle.
    fill(8);
    wq.delete();
    pulse_start();
    send(8'h00, 1);
    send(8'h08, 1);
    send(pl[0], 1);
    send(pl[1], 1);
    rx_valid = 1'b1;
    rx_data  = pl[2];
    rst      = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_nwr", 32'(wq.size()), 2);
    for (int i = 0; i < 2 && i < wq.size(); i++) begin
      e = {AW'(BASE + i), pl[i]};
      chk($sformatf("abort_wr%0d", i), 32'(wq[i]), 32'(e));
    end
    chk("abort_cpurst", 32'(cpu_rst), 1);
    chk("abort_cnt", 32'(byte_cnt), 0);
    chk("abort_rdy", 32'(rx_ready), 0);
    chk("abort_we", 32'(mem_we), 0);
    tick();
    chk("abort_idle_rdy", 32'(rx_ready), 0);
    chk("abort_idle_we", 32'(mem_we), 0);
    chk("abort_idle_done", 32'(done), 0);
    rx_valid = 1'b0;
    tick();

    for (int f = 0; f < 30; f++) begin
      kind = $urandom_range(0, 9);
      if (kind == 0)
        len = 16'(4 * $urandom_range(0, 16) + $urandom_range(1, 3));
      else if (kind == 1)
        len = 16'(1024 + 4 * $urandom_range(1, 200));
      else
        len = 16'(4 * $urandom_range(0, 16));
      fill(int'(len) <= 1024 ? int'(len) : 0);
      ck = xsum(pl.size());
      if ($urandom_range(0, 3) == 0)
        ck ^= 8'($urandom_range(1, 255));
      frame(len, ck, 2, $sformatf("rnd%0d", f));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
